regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the 8-bit datapath and its wider variants. It provides N_RD asynchronous read ports and one synchronous write port. Same-cycle write-to-read forwarding and a hardwired-zero register are both optional. A sequenced bulk-clear engine with a busy/done handshake replaces the old single-cycle reset-clear. It sits between decode (read addresses) and writeback (write port) in the CPU core.

Parameters:
DATA_W, 8, width of each register in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
N_RD, 2, number of read ports (>=1)
ZERO_REG, 0, 1 = register 0 always reads 0 and writes to it are discarded
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rd_addr  in  N_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
clr_req  in  1  request a bulk clear of all registers
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst_n=0, async): all registers 0; FSM = IDLE; clear pointer 0; clr_busy=0; clr_done=0. rd_data reflects the zeroed array immediately.
- Write: at posedge clk, if wr_en && state==IDLE && !(ZERO_REG && wr_addr==0), then reg[wr_addr] <= wr_data. Otherwise no change.
- Read: combinational, zero latency. rd_data[i] = reg[rd_addr[i]].
- ZERO_REG=1: any port addressing 0 returns 0, regardless of bypass.
- BYPASS=1: if wr_en && state==IDLE && wr_addr==rd_addr[i] && the write is not discarded, rd_data[i] = wr_data in the same cycle.
- BYPASS=0: the read returns the pre-write value; the new value is visible the cycle after the edge.
- Multiple read ports may address the same register; each gets the identical value.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req=1; ptr <= 0.
  - CLEAR: each cycle reg[ptr] <= 0 and ptr <= ptr+1. When ptr==DEPTH-1, the last register is written and the FSM -> DONE.
  - DONE: clr_done=1 for exactly one cycle, then -> IDLE.
- Clear timing: clr_req sampled at edge k gives clr_busy=1 for cycles k+1..k+DEPTH, and clr_done=1 in cycle k+DEPTH+1.
- clr_busy=1 only in CLEAR; it is a registered decode of state.
- wr_en while clr_busy=1 or clr_done=1: the write is dropped, not queued, and there is no forwarding. The caller must stall on clr_busy.
- clr_req while in CLEAR or DONE: ignored; no restart.
- clr_req held high: a new clear starts in the cycle after DONE.
- Reads during CLEAR return live array contents: already-cleared entries read 0, pending entries read their old values.
- rst_n asserted mid-clear: immediate return to the reset state; no clr_done pulse.
- ptr is ADDR_W bits wide and wraps naturally; the terminal test is ptr==DEPTH-1.

Decomposition:
- Package regfile_pkg: typedef enum logic [1:0] clr_state_t {CLR_IDLE, CLR_RUN, CLR_DONE}; helper localparam DEPTH derived in the module from ADDR_W.
- One natural sub-module: regfile_clear_seq, holding the FSM, ptr, clr_busy and clr_done. It exports clr_we, clr_addr and a write_block signal to the array.
- The array, write logic, read muxes and bypass stay in regfile_mp.

Test Plan:
- Reset then read: rst_n=0 then 1; rd_addr={4'h3,4'hF} -> rd_data=16'h0000; clr_busy=0.
- Write/read with BYPASS=1: wr_en=1, wr_addr=5, wr_data=8'hA5, rd_addr[0]=5 -> rd_data[0]=8'hA5 in the same cycle. With BYPASS=0 it reads 8'h00 that cycle and 8'hA5 the next.
- Zero register with ZERO_REG=1: write 8'hFF to addr 0 -> all ports reading 0 return 8'h00, both same cycle and later. Write to addr 1 reads back 8'hFF.
- Bulk clear: fill regs 0..15 with 8'h10+i, pulse clr_req -> clr_busy high for 16 cycles and clr_done for 1 cycle; afterwards all regs read 8'h00. A wr_en to addr 7 during busy is dropped (reads 0 after done).
- Reset mid-clear: assert rst_n=0 at busy cycle 6 -> clr_busy=0 immediately, no clr_done, all regs 0. clr_req ignored mid-clear does not extend busy beyond 16 cycles.
- Port aliasing with N_RD=3: all ports rd_addr=9 after writing 8'h3C -> all three return 8'h3C.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the multi-port register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks a pointer over every register to zero it, with busy/done handshake.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              write_block_o
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, done_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) state_d = CLR_DONE;
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // busy/done are registered decodes of the next state so they align with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == CLR_RUN);
            done_q  <= (state_d == CLR_DONE);
        end
    end

    assign clr_busy_o    = busy_q;
    assign clr_done_o    = done_q;
    assign clr_we_o      = (state_q == CLR_RUN);
    assign clr_addr_o    = ptr_q;
    assign write_block_o = (state_q != CLR_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N_RD async read ports, one sync write port, optional bypass and hardwired zero,
// plus a sequenced bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we, write_block, wr_ok;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_req_i    (clr_req),
        .clr_busy_o   (clr_busy),
        .clr_done_o   (clr_done),
        .clr_we_o     (clr_we),
        .clr_addr_o   (clr_addr),
        .write_block_o(write_block)
    );

    assign wr_ok = wr_en && !write_block && !(ZERO_REG != 0 && wr_addr == '0);

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[r] <= '0;
            else if (clr_we && clr_addr == ADDR_W'(r)) mem_q[r] <= '0;
            else if (wr_ok && wr_addr == ADDR_W'(r)) mem_q[r] <= wr_data;
        end
    end

    // zero register dominates bypass, bypass dominates the stored value
    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && ra == '0)           ? '0      :
            (BYPASS != 0 && wr_ok && wr_addr == ra) ? wr_data :
                                                    mem_q[ra];
    end

endmodule
